// File: rtl/alu_pkg.sv
// Shared ALU definitions: operator codes, instruction field positions and issue-controller states.
package alu_pkg;

    typedef enum logic [2:0] {
        OpAdd         = 3'b000,
        OpSub         = 3'b001,
        OpGreaterThan = 3'b010,
        OpLessThan    = 3'b011,
        OpLeftShift   = 3'b100,
        OpRightShift  = 3'b101
    } alu_op_e;

    localparam int unsigned UseImmBit = 20;
    localparam int unsigned OprMsb    = 19;
    localparam int unsigned OprLsb    = 17;
    localparam int unsigned RdMsb     = 16;
    localparam int unsigned RdLsb     = 14;
    localparam int unsigned Rs1Msb    = 13;
    localparam int unsigned Rs1Lsb    = 11;
    localparam int unsigned Rs2Msb    = 10;
    localparam int unsigned Rs2Lsb    = 8;
    localparam int unsigned ImmMsb    = 7;
    localparam int unsigned ImmLsb    = 0;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StIssue = 2'b01,
        StWrite = 2'b10
    } issue_state_e;

    // Codes 110 and 111 have no ALU function.
    function automatic logic is_illegal_op(input logic [2:0] op);
        return op[2] & op[1];
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// Register file: two asynchronous read ports, one synchronous write port, r0 reads as zero.
module alu_regfile
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] i_raddr_a,
    output logic [DATA_W-1:0] o_rdata_a,
    input  logic [ADDR_W-1:0] i_raddr_b,
    output logic [DATA_W-1:0] o_rdata_b,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata
);

    localparam int unsigned NumRegs = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_regs [NumRegs];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NumRegs; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we && (i_waddr != '0)) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a = (i_raddr_a == '0) ? '0 : r_regs[i_raddr_a];
    assign o_rdata_b = (i_raddr_b == '0) ? '0 : r_regs[i_raddr_b];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/writeback controller for the 32-bit ALU: IDLE -> ISSUE -> WRITE, one instruction in flight.
// Optional ALU_IMM_OPERAND_EN: instr[20] selects zero-extended imm8 as operand 2.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REG_ADDR_W = 3,
    parameter int unsigned INSTR_W    = 21
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [INSTR_W-1:0] instr,
    input  logic               instr_valid,
    output logic               instr_ready,
    output logic [DATA_W-1:0]  alu_op1,
    output logic [DATA_W-1:0]  alu_op2,
    output logic [2:0]         alu_operator,
    input  logic [DATA_W-1:0]  alu_result,
    input  logic               alu_is_zero,
    output logic [DATA_W-1:0]  result_out,
    output logic               zero_flag,
    output logic               done,
    output logic               illegal
);

    issue_state_e r_state, w_state_next;

    logic [DATA_W-1:0]     r_op1, r_op2, r_result;
    logic [2:0]            r_operator;
    logic [REG_ADDR_W-1:0] r_rd;
    logic                  r_illegal, r_zero;

    logic [REG_ADDR_W-1:0] w_rs1, w_rs2, w_rd;
    logic [2:0]            w_opr;
    logic [DATA_W-1:0]     w_rdata_a, w_rdata_b, w_op2;
    logic                  w_accept, w_we;

    assign w_opr = instr[OprMsb:OprLsb];
    assign w_rd  = instr[RdMsb:RdLsb];
    assign w_rs1 = instr[Rs1Msb:Rs1Lsb];
    assign w_rs2 = instr[Rs2Msb:Rs2Lsb];

`ifdef ALU_IMM_OPERAND_EN
    assign w_op2 = instr[UseImmBit] ? {{(DATA_W-8){1'b0}}, instr[ImmMsb:ImmLsb]} : w_rdata_b;
`else
    logic w_unused_imm;
    assign w_unused_imm = ^{instr[UseImmBit], instr[ImmMsb:ImmLsb]};
    assign w_op2        = w_rdata_b;
`endif

    assign instr_ready = (r_state == StIdle);
    assign w_accept    = instr_valid && instr_ready;
    // rd==0 is filtered inside the register file.
    assign w_we        = (r_state == StWrite) && !r_illegal;

    alu_regfile #(
        .DATA_W (DATA_W),
        .ADDR_W (REG_ADDR_W)
    ) u_regfile (
        .clk       (clk),
        .reset     (reset),
        .i_raddr_a (w_rs1),
        .o_rdata_a (w_rdata_a),
        .i_raddr_b (w_rs2),
        .o_rdata_b (w_rdata_b),
        .i_we      (w_we),
        .i_waddr   (r_rd),
        .i_wdata   (r_result)
    );

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (w_accept) w_state_next = StIssue;
            StIssue: w_state_next = StWrite;
            StWrite: w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= StIdle;
            r_op1      <= '0;
            r_op2      <= '0;
            r_operator <= '0;
            r_rd       <= '0;
            r_illegal  <= 1'b0;
            r_result   <= '0;
            r_zero     <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_op1      <= w_rdata_a;
                r_op2      <= w_op2;
                r_operator <= w_opr;
                r_rd       <= w_rd;
                r_illegal  <= is_illegal_op(w_opr);
            end
            if ((r_state == StIssue) && !r_illegal) begin
                r_result <= alu_result;
                r_zero   <= alu_is_zero;
            end
        end
    end

    assign alu_op1      = r_op1;
    assign alu_op2      = r_op2;
    assign alu_operator = r_operator;
    assign result_out   = r_result;
    assign zero_flag    = r_zero;
    assign done         = (r_state == StWrite);
    assign illegal      = (r_state == StWrite) && r_illegal;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: behavioural ALU, per-cycle reference model and directed literal checks.
module tb_alu_issue_ctrl;

    logic        clk;
    logic        reset;
    logic [20:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] alu_op1, alu_op2;
    logic [2:0]  alu_operator;
    logic [31:0] alu_result;
    logic        alu_is_zero;
    logic [31:0] result_out;
    logic        zero_flag;
    logic        done;
    logic        illegal;

    int n_checks = 0;
    int n_errors = 0;

    // Lets the bench plant register contents through an ordinary retirement.
    logic        alu_force_en;
    logic [31:0] alu_force_val;

    alu_issue_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .alu_op1      (alu_op1),
        .alu_op2      (alu_op2),
        .alu_operator (alu_operator),
        .alu_result   (alu_result),
        .alu_is_zero  (alu_is_zero),
        .result_out   (result_out),
        .zero_flag    (zero_flag),
        .done         (done),
        .illegal      (illegal)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic [2:0] op);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return (a > b) ? 32'd1 : 32'd0;
            3'd3:    return (a < b) ? 32'd1 : 32'd0;
            3'd4:    return a << b;
            3'd5:    return a >> b;
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    always_comb begin
        alu_result  = alu_force_en ? alu_force_val : alu_fn(alu_op1, alu_op2, alu_operator);
        alu_is_zero = (alu_result == 32'd0);
    end

    function automatic logic [20:0] mk(input logic imm_en, input logic [2:0] op,
                                       input logic [2:0] rd, input logic [2:0] rs1,
                                       input logic [2:0] rs2, input logic [7:0] imm);
        return {imm_en, op, rd, rs1, rs2, imm};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an instruction is "age" cycles past its accept (0 = none in flight).
    int          m_age;
    logic [31:0] m_rf [8];
    logic [31:0] m_op1, m_op2, m_res;
    logic [2:0]  m_opr, m_rd;
    logic        m_zero;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_age  <= 0;
            m_op1  <= '0;
            m_op2  <= '0;
            m_opr  <= '0;
            m_rd   <= '0;
            m_res  <= '0;
            m_zero <= 1'b0;
            for (int i = 0; i < 8; i++) m_rf[i] <= '0;
        end else begin
            if (m_age == 0 && instr_valid) begin
                m_age <= 1;
                m_op1 <= m_rf[instr[13:11]];
                m_opr <= instr[19:17];
                m_rd  <= instr[16:14];
`ifdef ALU_IMM_OPERAND_EN
                if (instr[20]) m_op2 <= {24'd0, instr[7:0]};
                else           m_op2 <= m_rf[instr[10:8]];
`else
                m_op2 <= m_rf[instr[10:8]];
`endif
            end else if (m_age == 1) begin
                m_age <= 2;
                if (m_opr < 3'd6) begin
                    m_res  <= alu_force_en ? alu_force_val : alu_fn(m_op1, m_op2, m_opr);
                    m_zero <= (alu_force_en ? alu_force_val : alu_fn(m_op1, m_op2, m_opr)) == 0;
                end
            end else if (m_age == 2) begin
                m_age <= 0;
                if (m_rd != 0 && m_opr < 3'd6) m_rf[m_rd] <= m_res;
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            check("ready", {31'd0, instr_ready}, {31'd0, m_age == 0});
            check("done", {31'd0, done}, {31'd0, m_age == 2});
            check("illegal", {31'd0, illegal}, {31'd0, (m_age == 2) && (m_opr >= 3'd6)});
            check("op1", alu_op1, m_op1);
            check("op2", alu_op2, m_op2);
            check("operator", {29'd0, alu_operator}, {29'd0, m_opr});
            check("result", result_out, m_res);
            check("zero", {31'd0, zero_flag}, {31'd0, m_zero});
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (!instr_ready && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!instr_ready) check("idle_timeout", 32'd0, 32'd1);
    endtask

    // Accepts one instruction; returns #1 after the accept edge (controller in ISSUE).
    task automatic start(input logic [20:0] ins, input logic fen, input logic [31:0] fval);
        wait_idle();
        instr         = ins;
        instr_valid   = 1'b1;
        alu_force_en  = fen;
        alu_force_val = fval;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic finish_instr();
        step();
        step();
        alu_force_en = 1'b0;
    endtask

    task automatic read_reg(input logic [2:0] r, output logic [31:0] val);
        start(mk(1'b0, 3'd0, 3'd0, r, 3'd0, 8'd0), 1'b0, 32'd0);
        val = alu_op1;
        finish_instr();
    endtask

    logic [31:0] v;
    int          acc;

    initial begin
        reset         = 1'b1;
        instr         = '0;
        instr_valid   = 1'b0;
        alu_force_en  = 1'b0;
        alu_force_val = '0;
        #3;
        check("rst_ready", {31'd0, instr_ready}, 32'd1);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_result", result_out, 32'd0);
        check("rst_op1", alu_op1, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset while an instruction sits in ISSUE drops it entirely.
        start(mk(1'b0, 3'd0, 3'd1, 3'd0, 3'd0, 8'd0), 1'b1, 32'd9);
        reset = 1'b1;
        #2;
        check("mid_rst_ready", {31'd0, instr_ready}, 32'd1);
        check("mid_rst_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        reset        = 1'b0;
        alu_force_en = 1'b0;
        step();
        check("mid_rst_no_done", {31'd0, done}, 32'd0);
        read_reg(3'd1, v);
        check("mid_rst_r1", v, 32'd0);

        // Preload r1=5, r2=3.
        start(mk(1'b0, 3'd0, 3'd1, 3'd0, 3'd0, 8'd0), 1'b1, 32'd5);
        finish_instr();
        start(mk(1'b0, 3'd0, 3'd2, 3'd0, 3'd0, 8'd0), 1'b1, 32'd3);
        finish_instr();

        start(mk(1'b0, 3'd0, 3'd3, 3'd1, 3'd2, 8'd0), 1'b0, 32'd0);
        check("add_op1", alu_op1, 32'd5);
        check("add_op2", alu_op2, 32'd3);
        check("add_done_issue", {31'd0, done}, 32'd0);
        step();
        check("add_done", {31'd0, done}, 32'd1);
        check("add_result", result_out, 32'd8);
        check("add_zero", {31'd0, zero_flag}, 32'd0);
        step();
        read_reg(3'd3, v);
        check("r3", v, 32'd8);

        start(mk(1'b0, 3'd1, 3'd4, 3'd1, 3'd1, 8'd0), 1'b0, 32'd0);
        step();
        check("sub_result", result_out, 32'd0);
        check("sub_zero", {31'd0, zero_flag}, 32'd1);
        step();

        start(mk(1'b0, 3'd0, 3'd0, 3'd1, 3'd2, 8'd0), 1'b0, 32'd0);
        step();
        check("rd0_done", {31'd0, done}, 32'd1);
        step();
        read_reg(3'd0, v);
        check("r0", v, 32'd0);

        // Last retirement read r0, so result_out=0 and zero_flag=1 must survive.
        start(mk(1'b0, 3'd7, 3'd6, 3'd1, 3'd2, 8'd0), 1'b0, 32'd0);
        check("ill_operator", {29'd0, alu_operator}, 32'd7);
        step();
        check("ill_done", {31'd0, done}, 32'd1);
        check("ill_flag", {31'd0, illegal}, 32'd1);
        check("ill_result", result_out, 32'd0);
        check("ill_zero", {31'd0, zero_flag}, 32'd1);
        step();
        read_reg(3'd6, v);
        check("r6", v, 32'd0);

        // instr_valid held high: one accept every 3 cycles.
        wait_idle();
        instr       = mk(1'b0, 3'd0, 3'd5, 3'd1, 3'd2, 8'd0);
        instr_valid = 1'b1;
        acc         = 0;
        repeat (9) begin
            @(negedge clk);
            if (instr_ready && instr_valid) acc++;
        end
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        check("throughput", acc, 32'd3);
        read_reg(3'd5, v);
        check("r5", v, 32'd8);

        start(mk(1'b1, 3'd4, 3'd7, 3'd1, 3'd2, 8'hFF), 1'b0, 32'd0);
        check("imm_op1", alu_op1, 32'd5);
`ifdef ALU_IMM_OPERAND_EN
        check("imm_op2", alu_op2, 32'd255);
        step();
        check("imm_result", result_out, 32'd0);
`else
        check("imm_op2", alu_op2, 32'd3);
        step();
        check("imm_result", result_out, 32'd40);
`endif
        step();

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
